// File: rtl/tl45_pkg.sv
// Shared types and opcode constants for the tl45 core front end.
// The store opcodes decide whether sr2 matters to the load-use hazard check.
package tl45_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 4;
  localparam int OPC_W_DEF  = 5;

  typedef logic [REG_AW_DEF-1:0] reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] data_t;

  typedef enum logic [OPC_W_DEF-1:0] {
    OP_NOP  = 5'h00,
    OP_ADD  = 5'h01,
    OP_SUB  = 5'h02,
    OP_AND  = 5'h03,
    OP_OR   = 5'h04,
    OP_XOR  = 5'h05,
    OP_SHL  = 5'h06,
    OP_SHR  = 5'h07,
    OP_CMP  = 5'h08,
    OP_JMP  = 5'h09,
    OP_CALL = 5'h0A,
    OP_RET  = 5'h0B,
    OP_LW   = 5'h14,
    OP_LB   = 5'h15,
    OP_SW   = 5'h16,
    OP_SB   = 5'h17
  } opcode_e;

  localparam reg_addr_t REG_ZERO = '0;

  // Stores read sr2 as data even when operand B is the immediate.
  function automatic logic is_store(input logic [OPC_W_DEF-1:0] op);
    return (op == OP_SW) || (op == OP_SB);
  endfunction

endpackage

// File: rtl/tl45_fwd_mux.sv
// Priority bypass for one source operand: r0, then EX, then WB, then register file.
module tl45_fwd_mux
  import tl45_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
) (
  input  logic [REG_AW-1:0] src,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              ex_valid,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_dr,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              wb_wr,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] value
);

  logic ex_hit;
  logic wb_hit;

  // A load in EX has no result yet; the hazard logic stalls on it instead.
  assign ex_hit = ex_valid && !ex_is_load && (ex_dr != REG_ZERO) && (ex_dr == src);
  assign wb_hit = wb_wr && (wb_addr != REG_ZERO) && (wb_addr == src);

  always_comb begin
    value = rf_data;
    if (src == REG_ZERO) begin
      value = '0;
    end else if (ex_hit) begin
      value = ex_result;
    end else if (wb_hit) begin
      value = wb_data;
    end
  end

endmodule

// File: rtl/tl45_register_read.sv
// Register-read stage: drives RF addresses, resolves operands with bypass,
// stalls on load-use and registers the result behind a valid/ready handshake.
module tl45_register_read
  import tl45_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4,
  parameter int OPC_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [OPC_W-1:0]  i_opcode,
  input  logic [REG_AW-1:0] i_dr,
  input  logic [REG_AW-1:0] i_sr1,
  input  logic [REG_AW-1:0] i_sr2,
  input  logic [DATA_W-1:0] i_imm,
  input  logic              i_use_imm,
  output logic [REG_AW-1:0] rf_readAdd1,
  output logic [REG_AW-1:0] rf_readAdd2,
  input  logic [DATA_W-1:0] rf_dataO1,
  input  logic [DATA_W-1:0] rf_dataO2,
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] ex_dr,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              ex_is_load,
  input  logic              wb_wrREG,
  input  logic [REG_AW-1:0] wb_writeAdd,
  input  logic [DATA_W-1:0] wb_dataI,
  input  logic              flush,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [OPC_W-1:0]  o_opcode,
  output logic [REG_AW-1:0] o_dr,
  output logic [DATA_W-1:0] o_opA,
  output logic [DATA_W-1:0] o_opB,
  output logic [DATA_W-1:0] o_sr2val
);

  logic [DATA_W-1:0] sr1_val;
  logic [DATA_W-1:0] sr2_val;
  logic              hazard;
  logic              adv;
  logic              load_en;

  logic              o_valid_q,  o_valid_d;
  logic [OPC_W-1:0]  o_opcode_q, o_opcode_d;
  logic [REG_AW-1:0] o_dr_q,     o_dr_d;
  logic [DATA_W-1:0] o_opA_q,    o_opA_d;
  logic [DATA_W-1:0] o_opB_q,    o_opB_d;
  logic [DATA_W-1:0] o_sr2val_q, o_sr2val_d;

  // Addresses follow the input even while stalled so held operands stay fresh.
  assign rf_readAdd1 = i_sr1;
  assign rf_readAdd2 = i_sr2;

  tl45_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_a (
    .src       (i_sr1),
    .rf_data   (rf_dataO1),
    .ex_valid  (ex_valid),
    .ex_is_load(ex_is_load),
    .ex_dr     (ex_dr),
    .ex_result (ex_result),
    .wb_wr     (wb_wrREG),
    .wb_addr   (wb_writeAdd),
    .wb_data   (wb_dataI),
    .value     (sr1_val)
  );

  tl45_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_b (
    .src       (i_sr2),
    .rf_data   (rf_dataO2),
    .ex_valid  (ex_valid),
    .ex_is_load(ex_is_load),
    .ex_dr     (ex_dr),
    .ex_result (ex_result),
    .wb_wr     (wb_wrREG),
    .wb_addr   (wb_writeAdd),
    .wb_data   (wb_dataI),
    .value     (sr2_val)
  );

  always_comb begin
    hazard = i_valid && ex_valid && ex_is_load && (ex_dr != REG_ZERO) &&
             ((ex_dr == i_sr1) ||
              (!i_use_imm && (ex_dr == i_sr2)) ||
              (is_store(i_opcode) && (ex_dr == i_sr2)));
    adv     = !o_valid_q || o_ready;
    i_ready = adv && !hazard && !flush;
    load_en = i_ready && i_valid;
  end

  always_comb begin
    o_valid_d  = o_valid_q;
    o_opcode_d = o_opcode_q;
    o_dr_d     = o_dr_q;
    o_opA_d    = o_opA_q;
    o_opB_d    = o_opB_q;
    o_sr2val_d = o_sr2val_q;
    if (flush) begin
      o_valid_d = 1'b0;
    end else if (adv) begin
      o_valid_d = i_valid && !hazard;
    end
    if (load_en) begin
      o_opcode_d = i_opcode;
      o_dr_d     = i_dr;
      o_opA_d    = sr1_val;
      o_opB_d    = i_use_imm ? i_imm : sr2_val;
      o_sr2val_d = sr2_val;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_valid_q  <= 1'b0;
      o_opcode_q <= '0;
      o_dr_q     <= '0;
      o_opA_q    <= '0;
      o_opB_q    <= '0;
      o_sr2val_q <= '0;
    end else begin
      o_valid_q  <= o_valid_d;
      o_opcode_q <= o_opcode_d;
      o_dr_q     <= o_dr_d;
      o_opA_q    <= o_opA_d;
      o_opB_q    <= o_opB_d;
      o_sr2val_q <= o_sr2val_d;
    end
  end

  assign o_valid  = o_valid_q;
  assign o_opcode = o_opcode_q;
  assign o_dr     = o_dr_q;
  assign o_opA    = o_opA_q;
  assign o_opB    = o_opB_q;
  assign o_sr2val = o_sr2val_q;

endmodule

// File: tb/tb_tl45_register_read.sv
// Directed bench for tl45_register_read: bypass, load-use stall, backpressure, flush, reset.
module tb_tl45_register_read;
  import tl45_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid, i_ready;
  logic [4:0]  i_opcode;
  logic [3:0]  i_dr, i_sr1, i_sr2;
  logic [31:0] i_imm;
  logic        i_use_imm;
  logic [3:0]  rf_readAdd1, rf_readAdd2;
  logic [31:0] rf_dataO1, rf_dataO2;
  logic        ex_valid, ex_is_load;
  logic [3:0]  ex_dr;
  logic [31:0] ex_result;
  logic        wb_wrREG;
  logic [3:0]  wb_writeAdd;
  logic [31:0] wb_dataI;
  logic        flush;
  logic        o_valid, o_ready;
  logic [4:0]  o_opcode;
  logic [3:0]  o_dr;
  logic [31:0] o_opA, o_opB, o_sr2val;

  logic [31:0] rf [16];
  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  assign rf_dataO1 = rf[rf_readAdd1];
  assign rf_dataO2 = rf[rf_readAdd2];

  tl45_register_read dut (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_ready(i_ready), .i_opcode(i_opcode), .i_dr(i_dr),
    .i_sr1(i_sr1), .i_sr2(i_sr2), .i_imm(i_imm), .i_use_imm(i_use_imm),
    .rf_readAdd1(rf_readAdd1), .rf_readAdd2(rf_readAdd2),
    .rf_dataO1(rf_dataO1), .rf_dataO2(rf_dataO2),
    .ex_valid(ex_valid), .ex_dr(ex_dr), .ex_result(ex_result), .ex_is_load(ex_is_load),
    .wb_wrREG(wb_wrREG), .wb_writeAdd(wb_writeAdd), .wb_dataI(wb_dataI),
    .flush(flush), .o_valid(o_valid), .o_ready(o_ready),
    .o_opcode(o_opcode), .o_dr(o_dr), .o_opA(o_opA), .o_opB(o_opB), .o_sr2val(o_sr2val)
  );

  task automatic drive(input logic v, input logic [4:0] op, input logic [3:0] dr,
                       input logic [3:0] s1, input logic [3:0] s2,
                       input logic ui, input logic [31:0] imm);
    i_valid = v; i_opcode = op; i_dr = dr; i_sr1 = s1; i_sr2 = s2;
    i_use_imm = ui; i_imm = imm;
  endtask

  task automatic no_bypass();
    ex_valid = 0; ex_is_load = 0; ex_dr = 0; ex_result = 0;
    wb_wrREG = 0; wb_writeAdd = 0; wb_dataI = 0;
  endtask

  task automatic test_reset();
    reset = 0; flush = 0; o_ready = 1; no_bypass();
    drive(0, OP_NOP, 0, 4'd6, 4'd9, 0, 0);
    #2;
    total_cnt++; if (o_valid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", o_valid); else pass_cnt++;
    total_cnt++; if ({o_opcode, o_dr, o_opA, o_opB, o_sr2val} !== '0) $display("FAIL reset_payload: got %h/%h/%h/%h/%h expected all 0", o_opcode, o_dr, o_opA, o_opB, o_sr2val); else pass_cnt++;
    total_cnt++; if ({rf_readAdd1, rf_readAdd2} !== {4'd6, 4'd9}) $display("FAIL reset_rfaddr: got %h %h expected 6 9", rf_readAdd1, rf_readAdd2); else pass_cnt++;
    @(negedge clk); reset = 1;
    $display("reset: done");
  endtask

  task automatic test_basic();
    @(negedge clk); drive(1, OP_ADD, 4'd3, 4'd1, 4'd2, 0, 0);
    @(posedge clk); #1;
    $display("basic ADD r3,r1,r2: valid=%0b opA=%h opB=%h dr=%0d", o_valid, o_opA, o_opB, o_dr);
    total_cnt++; if (o_valid !== 1'b1) $display("FAIL basic_valid: got %0b expected 1", o_valid); else pass_cnt++;
    total_cnt++; if (o_opA !== 32'd5) $display("FAIL basic_opA: got %h expected 5", o_opA); else pass_cnt++;
    total_cnt++; if (o_opB !== 32'd7) $display("FAIL basic_opB: got %h expected 7", o_opB); else pass_cnt++;
    total_cnt++; if (o_dr !== 4'd3 || o_opcode !== OP_ADD) $display("FAIL basic_dr_op: got %0d/%h expected 3/01", o_dr, o_opcode); else pass_cnt++;
    total_cnt++; if (o_sr2val !== 32'd7) $display("FAIL basic_sr2val: got %h expected 7", o_sr2val); else pass_cnt++;
  endtask

  task automatic test_bypass();
    @(negedge clk); drive(1, OP_SUB, 4'd4, 4'd1, 4'd2, 0, 0);
    ex_valid = 1; ex_dr = 1; ex_result = 32'h10;
    wb_wrREG = 1; wb_writeAdd = 1; wb_dataI = 32'h20;
    @(posedge clk); #1;
    $display("bypass EX+WB on r1: opA=%h", o_opA);
    total_cnt++; if (o_opA !== 32'h10) $display("FAIL bypass_ex_wins: got %h expected 10", o_opA); else pass_cnt++;
    @(negedge clk); ex_valid = 0;
    @(posedge clk); #1;
    $display("bypass WB only on r1: opA=%h", o_opA);
    total_cnt++; if (o_opA !== 32'h20) $display("FAIL bypass_wb: got %h expected 20", o_opA); else pass_cnt++;
    @(negedge clk); wb_writeAdd = 2; wb_dataI = 32'h77;
    @(posedge clk); #1;
    $display("bypass WB on r2: opA=%h opB=%h", o_opA, o_opB);
    total_cnt++; if (o_opA !== 32'd5 || o_opB !== 32'h77) $display("FAIL bypass_wb_sr2: got %h/%h expected 5/77", o_opA, o_opB); else pass_cnt++;
    @(negedge clk); no_bypass(); i_valid = 0;
  endtask

  task automatic test_load_use();
    @(negedge clk); drive(1, OP_ADD, 4'd5, 4'd1, 4'd2, 0, 0);
    ex_valid = 1; ex_is_load = 1; ex_dr = 2; ex_result = 32'hDEAD;
    #1;
    total_cnt++; if (i_ready !== 1'b0) $display("FAIL loaduse_ready: got %0b expected 0", i_ready); else pass_cnt++;
    @(posedge clk); #1;
    $display("load-use stall: valid=%0b", o_valid);
    total_cnt++; if (o_valid !== 1'b0) $display("FAIL loaduse_bubble: got %0b expected 0", o_valid); else pass_cnt++;
    @(negedge clk); ex_valid = 0; ex_is_load = 0;
    #1;
    total_cnt++; if (i_ready !== 1'b1) $display("FAIL loaduse_release: got %0b expected 1", i_ready); else pass_cnt++;
    @(posedge clk); #1;
    $display("load-use issue: valid=%0b opA=%h opB=%h", o_valid, o_opA, o_opB);
    total_cnt++; if (o_valid !== 1'b1 || o_opB !== 32'd7 || o_dr !== 4'd5) $display("FAIL loaduse_issue: got %0b/%h/%0d expected 1/7/5", o_valid, o_opB, o_dr); else pass_cnt++;
    @(negedge clk); drive(1, OP_ADD, 4'd5, 4'd1, 4'd2, 1, 32'h3);
    ex_valid = 1; ex_is_load = 1; ex_dr = 2;
    #1;
    total_cnt++; if (i_ready !== 1'b1) $display("FAIL loaduse_imm_nohaz: got %0b expected 1", i_ready); else pass_cnt++;
    i_opcode = OP_SW;
    #1;
    total_cnt++; if (i_ready !== 1'b0) $display("FAIL loaduse_store_haz: got %0b expected 0", i_ready); else pass_cnt++;
    $display("load-use imm/store: checked");
    @(posedge clk); @(negedge clk); no_bypass(); i_valid = 0;
  endtask

  task automatic test_stall();
    @(negedge clk); o_ready = 1; drive(1, OP_OR, 4'd6, 4'd4, 4'd5, 0, 0);
    @(posedge clk); #1;
    total_cnt++; if (o_valid !== 1'b1 || o_opA !== 32'h44) $display("FAIL stall_first: got %0b/%h expected 1/44", o_valid, o_opA); else pass_cnt++;
    @(negedge clk); o_ready = 0; drive(1, OP_AND, 4'd7, 4'd1, 4'd2, 0, 0);
    for (int c = 0; c < 3; c++) begin
      #1;
      total_cnt++; if (i_ready !== 1'b0) $display("FAIL stall_ready%0d: got %0b expected 0", c, i_ready); else pass_cnt++;
      @(posedge clk); #1;
      $display("stall cycle %0d: valid=%0b opA=%h opB=%h", c, o_valid, o_opA, o_opB);
      total_cnt++; if (o_valid !== 1'b1 || o_opA !== 32'h44 || o_opB !== 32'h55 || o_dr !== 4'd6) $display("FAIL stall_hold%0d: got %0b/%h/%h/%0d expected 1/44/55/6", c, o_valid, o_opA, o_opB, o_dr); else pass_cnt++;
      @(negedge clk);
    end
    total_cnt++; if (rf_readAdd1 !== 4'd1) $display("FAIL stall_rfaddr: got %h expected 1", rf_readAdd1); else pass_cnt++;
    o_ready = 1;
    #1;
    total_cnt++; if (i_ready !== 1'b1) $display("FAIL stall_resume_ready: got %0b expected 1", i_ready); else pass_cnt++;
    @(posedge clk); #1;
    $display("stall resume: opA=%h opB=%h dr=%0d", o_opA, o_opB, o_dr);
    total_cnt++; if (o_opA !== 32'd5 || o_opB !== 32'd7 || o_dr !== 4'd7) $display("FAIL stall_resume: got %h/%h/%0d expected 5/7/7", o_opA, o_opB, o_dr); else pass_cnt++;
    @(negedge clk); i_valid = 0;
  endtask

  task automatic test_zero_imm();
    @(negedge clk); drive(1, OP_ADD, 4'd8, 4'd0, 4'd3, 1, 32'hFFFF_FFFC);
    ex_valid = 1; ex_dr = 0; ex_result = 32'hFFFF;
    @(posedge clk); #1;
    $display("r0/imm: opA=%h opB=%h sr2val=%h", o_opA, o_opB, o_sr2val);
    total_cnt++; if (o_opA !== 32'd0) $display("FAIL zero_opA: got %h expected 0", o_opA); else pass_cnt++;
    total_cnt++; if (o_opB !== 32'hFFFF_FFFC) $display("FAIL imm_opB: got %h expected fffffffc", o_opB); else pass_cnt++;
    total_cnt++; if (o_sr2val !== 32'h33) $display("FAIL imm_sr2val: got %h expected 33", o_sr2val); else pass_cnt++;
    @(negedge clk); drive(1, OP_ADD, 4'd8, 4'd3, 4'd0, 0, 0);
    ex_valid = 0; wb_wrREG = 1; wb_writeAdd = 0; wb_dataI = 32'hABC;
    @(posedge clk); #1;
    $display("r0 wb: opA=%h opB=%h", o_opA, o_opB);
    total_cnt++; if (o_opB !== 32'd0 || o_opA !== 32'h33) $display("FAIL zero_wb: got %h/%h expected 33/0", o_opA, o_opB); else pass_cnt++;
    @(negedge clk); no_bypass(); i_valid = 0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] srcs [3];
    logic [31:0] exp [3];
    srcs[0] = 4'd1; srcs[1] = 4'd4; srcs[2] = 4'd3;
    exp[0] = 32'd5; exp[1] = 32'h44; exp[2] = 32'h33;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); drive(1, OP_XOR, 4'(k + 1), srcs[k], 4'd5, 0, 0);
      #1;
      total_cnt++; if (i_ready !== 1'b1) $display("FAIL b2b_ready%0d: got %0b expected 1", k, i_ready); else pass_cnt++;
      @(posedge clk); #1;
      $display("b2b %0d: valid=%0b opA=%h dr=%0d", k, o_valid, o_opA, o_dr);
      total_cnt++; if (o_valid !== 1'b1 || o_opA !== exp[k] || o_dr !== 4'(k + 1)) $display("FAIL b2b_out%0d: got %0b/%h/%0d expected 1/%h/%0d", k, o_valid, o_opA, o_dr, exp[k], k + 1); else pass_cnt++;
    end
    @(negedge clk); i_valid = 0;
  endtask

  task automatic test_flush_reset();
    @(negedge clk); drive(1, OP_ADD, 4'd3, 4'd1, 4'd2, 0, 0);
    @(posedge clk); #1;
    total_cnt++; if (o_valid !== 1'b1) $display("FAIL flush_pre: got %0b expected 1", o_valid); else pass_cnt++;
    @(negedge clk); flush = 1; o_ready = 0; drive(1, OP_SUB, 4'd9, 4'd4, 4'd5, 0, 0);
    #1;
    total_cnt++; if (i_ready !== 1'b0) $display("FAIL flush_ready: got %0b expected 0", i_ready); else pass_cnt++;
    @(posedge clk); #1;
    $display("flush: valid=%0b", o_valid);
    total_cnt++; if (o_valid !== 1'b0) $display("FAIL flush_valid: got %0b expected 0", o_valid); else pass_cnt++;
    @(negedge clk); flush = 0; o_ready = 1; i_valid = 0;
    @(posedge clk); #1;
    total_cnt++; if (o_valid !== 1'b0) $display("FAIL flush_not_consumed: got %0b expected 0", o_valid); else pass_cnt++;
    @(negedge clk); o_ready = 0; drive(1, OP_OR, 4'd6, 4'd4, 4'd5, 0, 0);
    @(posedge clk); #2;
    reset = 0;
    #1;
    $display("async reset mid-stall: valid=%0b opA=%h", o_valid, o_opA);
    total_cnt++; if (o_valid !== 1'b0 || o_opA !== 32'd0 || o_opcode !== 5'd0) $display("FAIL async_reset: got %0b/%h/%h expected 0/0/0", o_valid, o_opA, o_opcode); else pass_cnt++;
    @(negedge clk); reset = 1; o_ready = 1; drive(1, OP_ADD, 4'd2, 4'd1, 4'd2, 0, 0);
    @(posedge clk); #1;
    $display("post-reset resume: valid=%0b opA=%h opB=%h", o_valid, o_opA, o_opB);
    total_cnt++; if (o_valid !== 1'b1 || o_opA !== 32'd5 || o_opB !== 32'd7) $display("FAIL reset_resume: got %0b/%h/%h expected 1/5/7", o_valid, o_opA, o_opB); else pass_cnt++;
    @(negedge clk); i_valid = 0;
  endtask

  initial begin
    for (int r = 0; r < 16; r++) rf[r] = 32'h1000 + 32'(r);
    rf[0] = 32'h99; rf[1] = 32'd5; rf[2] = 32'd7; rf[3] = 32'h33;
    rf[4] = 32'h44; rf[5] = 32'h55;
    test_reset();
    test_basic();
    test_bypass();
    test_load_use();
    test_stall();
    test_zero_imm();
    test_back_to_back();
    test_flush_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/tl45_register_read.md
Name: tl45_register_read

Overview:
- Decode→execute stage of the tl45 core; sits directly upstream of the register file and consumes its read data.
- Accepts a decoded instruction and drives the register file read addresses from it.
- Merges register-file data with bypass values from the execute and writeback stages, and detects load-use hazards.
- Presents fully resolved operands to the ALU stage through a valid/ready pipeline register, with flush support.

Parameters:
- DATA_W, 32, operand/data width
- REG_AW, 4, register address width (16 architectural registers; r0 reads as zero)
- OPC_W, 5, opcode field width

Ports:
- clk  in  1  core clock; all state updates on posedge
- reset  in  1  asynchronous, active-low reset
- i_valid  in  1  decoded instruction valid
- i_ready  out  1  stage can accept the input this cycle
- i_opcode  in  OPC_W  decoded opcode
- i_dr  in  REG_AW  destination register
- i_sr1  in  REG_AW  source register 1
- i_sr2  in  REG_AW  source register 2
- i_imm  in  DATA_W  sign-extended immediate
- i_use_imm  in  1  operand B takes the immediate instead of sr2
- rf_readAdd1  out  REG_AW  to register file read port 1
- rf_readAdd2  out  REG_AW  to register file read port 2
- rf_dataO1  in  DATA_W  register file port 1 data, valid before the posedge of the same cycle
- rf_dataO2  in  DATA_W  register file port 2 data
- ex_valid  in  1  execute stage holds a writing instruction
- ex_dr  in  REG_AW  execute-stage destination
- ex_result  in  DATA_W  execute-stage ALU result
- ex_is_load  in  1  execute-stage instruction is a load; result not yet available
- wb_wrREG  in  1  writeback writing the register file this cycle
- wb_writeAdd  in  REG_AW  writeback destination
- wb_dataI  in  DATA_W  writeback data
- flush  in  1  squash the held output and the current input
- o_valid  out  1  output instruction valid
- o_ready  in  1  ALU stage accepts
- o_opcode  out  OPC_W  registered opcode
- o_dr  out  REG_AW  registered destination
- o_opA  out  DATA_W  resolved operand A
- o_opB  out  DATA_W  resolved operand B (or immediate)
- o_sr2val  out  DATA_W  resolved sr2 value, used for store data

Behaviour:
- Reset low (asynchronous): o_valid=0; o_opcode, o_dr, o_opA, o_opB, o_sr2val = 0.
- rf_readAdd1/2 are driven combinationally from i_sr1/i_sr2 at all times, stall included, so held data is re-read every cycle.
- Operand resolution, per source register s, in priority order:
  - s==0 → 0
  - ex_valid && !ex_is_load && ex_dr==s → ex_result
  - wb_wrREG && wb_writeAdd==s → wb_dataI
  - otherwise → rf_dataO
- Bypass never matches when the destination is 0.
- Load-use hazard: hazard = i_valid && ex_valid && ex_is_load && ex_dr!=0 && (ex_dr==i_sr1 || (!i_use_imm && ex_dr==i_sr2) || ex_dr==i_sr2 for store opcodes).
- Output register may advance when adv = !o_valid || o_ready.
- i_ready = adv && !hazard && !flush.
- At posedge with flush=1: o_valid←0; the input is not accepted.
- Else, at posedge with adv=1:
  - hazard → o_valid←0 (bubble)
  - else o_valid←i_valid; payload loaded when i_valid.
- At posedge with adv=0: all outputs hold.
- Output payload must not change while o_valid && !o_ready.
- Latency: one cycle from input acceptance to o_valid.
- Throughput: one instruction per cycle with no hazard.
- o_opB = i_use_imm ? i_imm : resolved sr2; o_sr2val = resolved sr2 always.
- Simultaneous EX and WB match on the same register → EX wins (younger).
- Reset asserted mid-stall → outputs clear immediately; resume cleanly after release.

Decomposition:
- tl45_pkg holds:
  - reg_addr_t
  - data_t
  - opcode enum, including the store/load opcode constants used for the hazard rule
  - REG_ZERO constant
- Sub-module tl45_fwd_mux, instantiated twice: one operand's priority bypass (zero/EX/WB/RF), purely combinational.

Test Plan:
1. Reset released; input ADD r3,r1,r2 with RF r1=5, r2=7, no bypass → next cycle o_valid=1, o_opA=5, o_opB=7, o_dr=3.
2. ex_valid, ex_dr=1, ex_result=0x10, and wb writing r1=0x20 in the same cycle, input reads sr1=1 → o_opA=0x10; drop ex_valid → o_opA=0x20.
3. ex_is_load, ex_dr=2, input sr2=2 without immediate → i_ready=0 and a bubble (o_valid=0) for one cycle; next cycle with ex_valid=0 the instruction issues using rf data.
4. o_ready=0 for 3 cycles with o_valid=1 → o_opA/o_opB stable and i_ready=0; o_ready=1 → next instruction issues on the following edge.
5. Source r0 with ex_dr=0, ex_result=0xFFFF → operand reads 0; i_use_imm=1, imm=-4 → o_opB=0xFFFFFFFC.
6. flush while o_valid=1 and i_valid=1 → next cycle o_valid=0 and the input is not consumed; async reset pulsed mid-cycle → o_valid=0 immediately, without waiting for a clock edge.
